cpu_int_ctrl: RTL and testbench
===============================

Name: cpu_int_ctrl

Overview:
- Generates the `nmi` and `irq` requests consumed by the 65816 CPU controller; the controller samples `irq` at opcode fetch and during WAI.
- Implements the $4200/$4207-$420A write registers and the $4210/$4211 read-clear status registers.
- Sits between the PPU timing counters and the CPU core, on the B/CPU register bus.

Parameters:
CPU_VERSION, 4'h2, value returned in RDNMI[3:0]
H_LAST, 9'd339, last valid hcount; a programmed HTIME above this never matches

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
dot_en  in  1  one-cycle strobe when hcount/vcount advance by one dot
hcount  in  9  current dot within line, 0..H_LAST
vcount  in  9  current line
vblank_start  in  1  one-cycle pulse at the first dot of vblank
vblank_end  in  1  one-cycle pulse at the first dot after vblank (line 0)
reg_cs  in  1  address in $4200-$421F
reg_addr  in  5  CPU address[4:0]
reg_wdata  in  8  CPU write data
reg_write  in  1  one-cycle write strobe, once per CPU access
reg_read  in  1  one-cycle read strobe, once per CPU access
reg_rdata  out  8  read data, combinational from current state
nmi  out  1  NMI request level; the CPU edge-detects it
irq  out  1  IRQ request level
auto_joy_en  out  1  NMITIMEN[0] for the joypad block

Behaviour:
- Reset values: all registers, nmi_flag and timeup cleared; `nmi`, `irq`, `auto_joy_en` and `reg_rdata` are 0.
- State:
  - nmitimen: bit7 nmi_en, bits5:4 irq_mode, bit0 auto_joy.
  - htime[8:0]: written by $4207 (low byte) and $4208[0] (bit 8).
  - vtime[8:0]: written by $4209 (low byte) and $420A[0] (bit 8).
  - nmi_flag, timeup.
- Writes take effect on the clk edge where reg_cs & reg_write are high. Unlisted addresses are ignored.
- nmi_flag:
  - Set on vblank_start.
  - Cleared on vblank_end, or by reg_read of $4210.
  - Set beats clear in the same cycle.
- nmi = nmi_flag & nmi_en, combinational. Setting nmi_en while nmi_flag=1 therefore raises nmi immediately (retrigger). Clearing nmi_en drops nmi.
- Timer match is evaluated only in cycles where dot_en=1, using the hcount/vcount values present in that cycle:
  - irq_mode 00: never matches.
  - irq_mode 01: matches when hcount==htime (once per line).
  - irq_mode 10: matches when vcount==vtime && hcount==0.
  - irq_mode 11: matches when vcount==vtime && hcount==htime.
- timeup:
  - Set on match.
  - Cleared by reg_read of $4211, or by any $4200 write with irq_mode=00.
  - Set beats clear in the same cycle.
  - A write of htime/vtime does not clear timeup.
- irq = timeup, combinational. It stays high until cleared; no automatic deassert at end of dot.
- Register writes in the same cycle as a match: the match compare uses the pre-write htime/vtime/irq_mode.
- reg_rdata (zero when not selected):
  - $4210: {nmi_flag, 3'b000, CPU_VERSION}.
  - $4211: {timeup, 7'b0}.
  - Other addresses: 8'h00.
  - The returned value is the pre-clear state for that cycle.
- Read side effects occur only when reg_cs & reg_read are high. Reads with reg_read=0 are side-effect free.
- Reset asserted mid-frame returns all state to reset values immediately (asynchronous). Matching resumes normally after release.
- Counter wrap: no internal counters. Any vcount value is accepted; htime > H_LAST never matches.

Test Plan:
- After reset, read $4210 -> 8'h02. Pulse vblank_start, read $4210 -> 8'h82, read again -> 8'h02.
- Write $4200=8'h00 and raise nmi_flag, then write $4200=8'h80 -> nmi rises the cycle after the write. Pulse vblank_end -> nmi falls.
- Write $4200=8'h10, HTIME=9'd100; sweep hcount 0..339 with dot_en -> irq rises the cycle after the hcount=100 dot. Read $4211 returns 8'h80 and clears irq.
- Write $4200=8'h30, VTIME=9'd225, HTIME=9'd0x120:
  - vcount=225, hcount=288 -> irq=1.
  - Same dot on vcount=224 -> no irq.
  - HTIME=9'd350 -> never fires.
- vblank_start in the same cycle as a $4210 read -> read returns bit7=0 and nmi_flag ends at 1. Same for a match coinciding with a $4211 read.
- With timeup=1, write $4200=8'h00 -> irq=0 next cycle. Assert reset while nmi=1 -> nmi=0 and irq=0 asynchronously.

Source files
------------

// File: rtl/cpu_int_ctrl.sv
// ============================================================================
// Module   : cpu_int_ctrl
// Brief    : NMI/IRQ request generation and $4200/$4207-$420A/$4210/$4211 regs
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_int_ctrl #(
  parameter logic [3:0] CPU_VERSION = 4'h2,
  parameter logic [8:0] H_LAST      = 9'd339
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dot_en,
  input  logic [8:0] hcount,
  input  logic [8:0] vcount,
  input  logic       vblank_start,
  input  logic       vblank_end,
  input  logic       reg_cs,
  input  logic [4:0] reg_addr,
  input  logic [7:0] reg_wdata,
  input  logic       reg_write,
  input  logic       reg_read,
  output logic [7:0] reg_rdata,
  output logic       nmi,
  output logic       irq,
  output logic       auto_joy_en
);

  localparam logic [4:0] c_NMITIMEN = 5'h00;
  localparam logic [4:0] c_HTIMEL   = 5'h07;
  localparam logic [4:0] c_HTIMEH   = 5'h08;
  localparam logic [4:0] c_VTIMEL   = 5'h09;
  localparam logic [4:0] c_VTIMEH   = 5'h0A;
  localparam logic [4:0] c_RDNMI    = 5'h10;
  localparam logic [4:0] c_TIMEUP   = 5'h11;

  logic       r_nmi_en;
  logic [1:0] r_irq_mode;
  logic       r_auto_joy;
  logic [8:0] r_htime;
  logic [8:0] r_vtime;
  logic       r_nmi_flag;
  logic       r_timeup;

  logic w_wr;
  logic w_rd;
  logic w_h_hit;
  logic w_v_hit;
  logic w_match;
  logic w_nmi_clr;
  logic w_timeup_clr;

  assign w_wr = reg_cs & reg_write;
  assign w_rd = reg_cs & reg_read;

  // An HTIME past the last dot must never match, even if hcount ever got there.
  assign w_h_hit = (hcount == r_htime) && (r_htime <= H_LAST);
  assign w_v_hit = (vcount == r_vtime);

  always_comb begin
    w_match = 1'b0;
    if (dot_en) begin
      case (r_irq_mode)
        2'b01:   w_match = w_h_hit;
        2'b10:   w_match = w_v_hit && (hcount == 9'd0);
        2'b11:   w_match = w_v_hit && w_h_hit;
        default: w_match = 1'b0;
      endcase
    end
  end

  assign w_nmi_clr    = vblank_end || (w_rd && (reg_addr == c_RDNMI));
  assign w_timeup_clr = (w_rd && (reg_addr == c_TIMEUP)) ||
                        (w_wr && (reg_addr == c_NMITIMEN) && (reg_wdata[5:4] == 2'b00));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_nmi_en   <= 1'b0;
      r_irq_mode <= 2'b00;
      r_auto_joy <= 1'b0;
      r_htime    <= 9'd0;
      r_vtime    <= 9'd0;
      r_nmi_flag <= 1'b0;
      r_timeup   <= 1'b0;
    end else begin
      if (w_wr) begin
        case (reg_addr)
          c_NMITIMEN: begin
            r_nmi_en   <= reg_wdata[7];
            r_irq_mode <= reg_wdata[5:4];
            r_auto_joy <= reg_wdata[0];
          end
          c_HTIMEL: r_htime[7:0] <= reg_wdata;
          c_HTIMEH: r_htime[8]   <= reg_wdata[0];
          c_VTIMEL: r_vtime[7:0] <= reg_wdata;
          c_VTIMEH: r_vtime[8]   <= reg_wdata[0];
          default:  ;
        endcase
      end

      // Set events take priority over clears arriving in the same cycle.
      if (vblank_start)   r_nmi_flag <= 1'b1;
      else if (w_nmi_clr) r_nmi_flag <= 1'b0;

      if (w_match)           r_timeup <= 1'b1;
      else if (w_timeup_clr) r_timeup <= 1'b0;
    end
  end

  always_comb begin
    reg_rdata = 8'h00;
    if (reg_cs && !reset) begin
      case (reg_addr)
        c_RDNMI:  reg_rdata = {r_nmi_flag, 3'b000, CPU_VERSION};
        c_TIMEUP: reg_rdata = {r_timeup, 7'b0};
        default:  reg_rdata = 8'h00;
      endcase
    end
  end

  assign nmi         = r_nmi_flag & r_nmi_en;
  assign irq         = r_timeup;
  assign auto_joy_en = r_auto_joy;

endmodule

`default_nettype wire

// File: tb/tb_cpu_int_ctrl.sv
// ============================================================================
// Module   : tb_cpu_int_ctrl
// Brief    : Directed self-checking bench for cpu_int_ctrl
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_int_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       dot_en = 1'b0;
  logic [8:0] hcount = 9'd0;
  logic [8:0] vcount = 9'd0;
  logic       vblank_start = 1'b0;
  logic       vblank_end = 1'b0;
  logic       reg_cs = 1'b0;
  logic [4:0] reg_addr = 5'd0;
  logic [7:0] reg_wdata = 8'd0;
  logic       reg_write = 1'b0;
  logic       reg_read = 1'b0;
  logic [7:0] reg_rdata;
  logic       nmi;
  logic       irq;
  logic       auto_joy_en;

  int total = 0;
  int bad = 0;
  logic [7:0] rv;

  cpu_int_ctrl dut (
    .clk(clk), .reset(reset), .dot_en(dot_en), .hcount(hcount), .vcount(vcount),
    .vblank_start(vblank_start), .vblank_end(vblank_end), .reg_cs(reg_cs),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_write(reg_write),
    .reg_read(reg_read), .reg_rdata(reg_rdata), .nmi(nmi), .irq(irq),
    .auto_joy_en(auto_joy_en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    reg_cs = 1'b1; reg_write = 1'b1; reg_addr = a; reg_wdata = d;
    tick();
    reg_cs = 1'b0; reg_write = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [7:0] d);
    reg_cs = 1'b1; reg_read = 1'b1; reg_addr = a;
    #1;
    d = reg_rdata;
    tick();
    reg_cs = 1'b0; reg_read = 1'b0;
  endtask

  task automatic dot(input logic [8:0] v, input logic [8:0] h);
    vcount = v; hcount = h; dot_en = 1'b1;
    tick();
    dot_en = 1'b0;
  endtask

  task automatic pulse_vbs();
    vblank_start = 1'b1;
    tick();
    vblank_start = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_nmi", {7'b0, nmi}, 8'h00);
    chk("rst_irq", {7'b0, irq}, 8'h00);
    chk("rst_joy", {7'b0, auto_joy_en}, 8'h00);
    chk("rst_rdata", reg_rdata, 8'h00);
    @(posedge clk); #1;
    reset = 1'b0;
    tick();

    // RDNMI version and flag read-clear
    rd(5'h10, rv); chk("rdnmi_idle", rv, 8'h02);
    pulse_vbs();
    rd(5'h10, rv); chk("rdnmi_set", rv, 8'h82);
    rd(5'h10, rv); chk("rdnmi_clr", rv, 8'h02);

    // NMI retrigger by enabling while flag set, drop on vblank_end
    wr(5'h00, 8'h00);
    pulse_vbs();
    chk("nmi_masked", {7'b0, nmi}, 8'h00);
    wr(5'h00, 8'h80);
    chk("nmi_retrig", {7'b0, nmi}, 8'h01);
    vblank_end = 1'b1; tick(); vblank_end = 1'b0;
    chk("nmi_vbend", {7'b0, nmi}, 8'h00);

    // H-only timer sweep
    wr(5'h00, 8'h10);
    wr(5'h07, 8'd100);
    wr(5'h08, 8'h00);
    for (int h = 0; h <= 339; h++) begin
      dot(9'd5, h[8:0]);
      chk($sformatf("hsweep_%0d", h), {7'b0, irq}, (h >= 100) ? 8'h01 : 8'h00);
    end
    rd(5'h11, rv); chk("timeup_read", rv, 8'h80);
    chk("irq_clr_read", {7'b0, irq}, 8'h00);

    // H+V timer
    wr(5'h00, 8'h30);
    wr(5'h09, 8'hE1);
    wr(5'h0A, 8'h00);
    wr(5'h07, 8'h20);
    wr(5'h08, 8'h01);
    dot(9'd225, 9'd288);
    chk("hv_match", {7'b0, irq}, 8'h01);
    rd(5'h11, rv); chk("hv_read", rv, 8'h80);
    dot(9'd224, 9'd288);
    chk("hv_wrong_line", {7'b0, irq}, 8'h00);
    wr(5'h07, 8'h5E);
    for (int h = 0; h <= 339; h++) dot(9'd225, h[8:0]);
    dot(9'd225, 9'd350);
    chk("htime_350_never", {7'b0, irq}, 8'h00);

    // V-only timer, and HTIME write leaves timeup alone
    wr(5'h00, 8'h20);
    dot(9'd225, 9'd1);
    chk("v_h1_nomatch", {7'b0, irq}, 8'h00);
    dot(9'd225, 9'd0);
    chk("v_match", {7'b0, irq}, 8'h01);
    wr(5'h07, 8'h20);
    chk("htime_wr_keeps", {7'b0, irq}, 8'h01);
    rd(5'h11, rv); chk("v_read", rv, 8'h80);
    chk("v_irq_clr", {7'b0, irq}, 8'h00);

    // vblank_start coinciding with RDNMI read
    vblank_start = 1'b1;
    rd(5'h10, rv);
    vblank_start = 1'b0;
    chk("coinc_nmi_rd", rv, 8'h02);
    rd(5'h10, rv); chk("coinc_nmi_flag", rv, 8'h82);

    // Match coinciding with TIMEUP read
    wr(5'h00, 8'h30);
    vcount = 9'd225; hcount = 9'd288; dot_en = 1'b1;
    rd(5'h11, rv);
    dot_en = 1'b0;
    chk("coinc_tu_rd", rv, 8'h00);
    chk("coinc_tu_irq", {7'b0, irq}, 8'h01);

    // Mode-00 write clears timeup
    wr(5'h00, 8'h00);
    chk("mode0_clr", {7'b0, irq}, 8'h00);

    // Asynchronous reset while nmi and irq are active
    pulse_vbs();
    wr(5'h00, 8'hB1);
    chk("pre_rst_nmi", {7'b0, nmi}, 8'h01);
    chk("pre_rst_joy", {7'b0, auto_joy_en}, 8'h01);
    dot(9'd225, 9'd288);
    chk("pre_rst_irq", {7'b0, irq}, 8'h01);
    #2;
    reset = 1'b1;
    #1;
    chk("async_nmi", {7'b0, nmi}, 8'h00);
    chk("async_irq", {7'b0, irq}, 8'h00);
    chk("async_joy", {7'b0, auto_joy_en}, 8'h00);
    tick();
    reset = 1'b0;
    tick();

    // Matching resumes after reset
    wr(5'h00, 8'h10);
    dot(9'd0, 9'd0);
    chk("post_rst_match", {7'b0, irq}, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
